pixel_port_arbiter: RTL and testbench



---
 rtl/pixel_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_pixel_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_port_arbiter.sv
// Round-robin arbiter sharing the VGA adapter pixel write port among burst drawers.
// Optional off-screen clipping is enabled with `define PIXEL_ARB_CLIP_EN.
module pixel_port_arbiter #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned XW            = 9,
  parameter int unsigned YW            = 8,
  parameter int unsigned CW            = 3,
  parameter int unsigned X_MAX         = 319,
  parameter int unsigned Y_MAX         = 239,
  parameter int unsigned MAX_BURST_CYC = 1024
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req,
  input  logic               hold,
  input  logic [NREQ-1:0]    pix_valid,
  input  logic [NREQ-1:0]    pix_last,
  input  logic [NREQ*XW-1:0] pix_x,
  input  logic [NREQ*YW-1:0] pix_y,
  input  logic [NREQ*CW-1:0] pix_colour,
  input  logic [NREQ-1:0]    blackout,
  output logic [NREQ-1:0]    pix_ready,
  output logic [NREQ-1:0]    grant,
  output logic [XW-1:0]      X,
  output logic [YW-1:0]      Y,
  output logic [CW-1:0]      colour,
  output logic               plot,
  output logic [NREQ-1:0]    burst_done,
  output logic               timeout_err
);

  localparam int unsigned IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WDW      = (MAX_BURST_CYC > 1) ? $clog2(MAX_BURST_CYC) : 1;
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(MAX_BURST_CYC - 1);
`ifdef PIXEL_ARB_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [WDW-1:0]    wd_q, wd_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [CW-1:0]     col_q, col_d;
  logic              plot_q, plot_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              tmo_q, tmo_d;

  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  int unsigned       cand;
  logic [XW-1:0]     beat_x;
  logic [YW-1:0]     beat_y;
  logic [CW-1:0]     beat_c;
  logic              accept;
  logic              last_acc;
  logic              on_screen;
  logic              visible;
  logic [IW-1:0]     ptr_next;

  // Round-robin search starting at the pointer, wrapping around
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr_q) + i) % NREQ;
      if (!sel_found && req[IW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(cand);
      end
    end
  end

  // Beat selection from the granted lane
  always_comb begin
    beat_x    = pix_x[gidx_q*XW +: XW];
    beat_y    = pix_y[gidx_q*YW +: YW];
    beat_c    = pix_colour[gidx_q*CW +: CW];
    accept    = (state_q == S_BURST) && pix_valid[gidx_q];
    last_acc  = accept && pix_last[gidx_q];
    on_screen = (beat_x <= XW'(X_MAX)) && (beat_y <= YW'(Y_MAX));
    visible   = !CLIP_EN || on_screen;
    ptr_next  = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
  end

  assign pix_ready = (state_q == S_BURST) ? grant_q : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    plot_d  = 1'b0;
    done_d  = '0;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!hold && sel_found) begin
          grant_d = NREQ'(1) << sel_idx;
          gidx_d  = sel_idx;
          wd_d    = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        wd_d = wd_q + WDW'(1);
        if (accept && visible) begin
          x_d    = beat_x;
          y_d    = beat_y;
          col_d  = blackout[gidx_q] ? '0 : beat_c;
          plot_d = 1'b1;
        end
        if (last_acc) begin
          done_d  = grant_q;
          ptr_d   = ptr_next;
          grant_d = '0;
          state_d = S_IDLE;
        end else if (wd_q == WD_LIMIT) begin
          // Watchdog abort; a beat accepted this cycle was still written above
          tmo_d   = 1'b1;
          ptr_d   = ptr_next;
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
      done_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant       = grant_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign colour      = col_q;
  assign plot        = plot_q;
  assign burst_done  = done_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_pixel_port_arbiter.sv
// Bench for pixel_port_arbiter: directed scenarios plus randomized traffic against a burst-level model.
module tb_pixel_port_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned XW   = 9;
  localparam int unsigned YW   = 8;
  localparam int unsigned CW   = 3;
  localparam int unsigned XMAX = 319;
  localparam int unsigned YMAX = 239;
  localparam int unsigned MAXB = 16;

  logic               clk = 1'b0;
  logic               resetn;
  logic [NREQ-1:0]    req;
  logic               hold;
  logic [NREQ-1:0]    pix_valid;
  logic [NREQ-1:0]    pix_last;
  logic [NREQ*XW-1:0] pix_x;
  logic [NREQ*YW-1:0] pix_y;
  logic [NREQ*CW-1:0] pix_colour;
  logic [NREQ-1:0]    blackout;
  logic [NREQ-1:0]    pix_ready;
  logic [NREQ-1:0]    grant;
  logic [XW-1:0]      dut_x;
  logic [YW-1:0]      dut_y;
  logic [CW-1:0]      colour;
  logic               plot;
  logic [NREQ-1:0]    burst_done;
  logic               timeout_err;

  pixel_port_arbiter #(
    .NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW),
    .X_MAX(XMAX), .Y_MAX(YMAX), .MAX_BURST_CYC(MAXB)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .hold(hold),
    .pix_valid(pix_valid), .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y),
    .pix_colour(pix_colour), .blackout(blackout), .pix_ready(pix_ready),
    .grant(grant), .X(dut_x), .Y(dut_y), .colour(colour), .plot(plot),
    .burst_done(burst_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Model: owner of the port (-1 when free), cycles spent in the burst, next index to favour
  int          m_owner;
  int          m_cyc;
  int          m_ptr;
  logic [31:0] e_x, e_y, e_col, e_done;
  logic        e_plot, e_tmo;
  int          mg;
  bit          found, fin, vis;
  logic [31:0] bx, by, bc;

  task automatic model_reset();
    m_owner = -1; m_cyc = 0; m_ptr = 0;
    e_x = 0; e_y = 0; e_col = 0; e_done = 0; e_plot = 0; e_tmo = 0;
  endtask

  always @(negedge resetn) model_reset();

  always @(posedge clk) begin
    if (!resetn) model_reset();
    else begin
      e_done = 0; e_tmo = 0; e_plot = 0;
      if (m_owner < 0) begin
        if (!hold && req != 0) begin
          found = 0;
          for (int k = 0; k < NREQ; k++)
            if (!found && req[(m_ptr + k) % NREQ]) begin
              found = 1; m_owner = (m_ptr + k) % NREQ;
            end
          m_cyc = 0;
        end
      end else begin
        mg = m_owner;
        m_cyc++;
        fin = 0;
        if (pix_valid[mg]) begin
          bx = 32'(pix_x[mg*XW +: XW]);
          by = 32'(pix_y[mg*YW +: YW]);
          bc = 32'(pix_colour[mg*CW +: CW]);
`ifdef PIXEL_ARB_CLIP_EN
          vis = (bx <= XMAX) && (by <= YMAX);
`else
          vis = 1;
`endif
          if (vis) begin
            e_x = bx; e_y = by; e_col = blackout[mg] ? 0 : bc; e_plot = 1;
          end
          if (pix_last[mg]) begin
            e_done = 32'(1) << mg; fin = 1;
          end
        end
        if (!fin && m_cyc == MAXB) begin
          e_tmo = 1; fin = 1;
        end
        if (fin) begin
          m_ptr = (mg + 1) % NREQ; m_owner = -1;
        end
      end
    end
    #1;
    chk("grant", 32'(grant), (m_owner >= 0) ? (32'(1) << m_owner) : 0);
    chk("pix_ready", 32'(pix_ready), (m_owner >= 0) ? (32'(1) << m_owner) : 0);
    chk("X", 32'(dut_x), e_x);
    chk("Y", 32'(dut_y), e_y);
    chk("colour", 32'(colour), e_col);
    chk("plot", 32'(plot), 32'(e_plot));
    chk("burst_done", 32'(burst_done), e_done);
    chk("timeout_err", 32'(timeout_err), 32'(e_tmo));
  end

  task automatic clear_inputs();
    req = '0; hold = 0; pix_valid = '0; pix_last = '0;
    pix_x = '0; pix_y = '0; pix_colour = '0; blackout = '0;
  endtask

  task automatic lane(input int r, input int x, input int y, input int c,
                      input bit v, input bit l, input bit b);
    pix_x[r*XW +: XW]      = XW'(x);
    pix_y[r*YW +: YW]      = YW'(y);
    pix_colour[r*CW +: CW] = CW'(c);
    pix_valid[r] = v; pix_last[r] = l; blackout[r] = b;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [NREQ-1:0] rr_exp [9];
    int last_pct;
    rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    clear_inputs();
    resetn = 0;
    repeat (2) @(negedge clk);
    chk("reset_grant", 32'(grant), 0);
    chk("reset_plot", 32'(plot), 0);
    chk("reset_X", 32'(dut_x), 0);
    resetn = 1;

    // 3-beat burst from requester 0
    req = 4'b0001; lane(0, 10, 20, 5, 1, 0, 0);
    @(negedge clk); chk("t1_grant", 32'(grant), 1); chk("t1_plot0", 32'(plot), 0); req = '0;
    @(negedge clk); chk("t1_x10", 32'(dut_x), 10); chk("t1_plot1", 32'(plot), 1);
    chk("t1_col", 32'(colour), 5); lane(0, 11, 20, 5, 1, 0, 0);
    @(negedge clk); chk("t1_x11", 32'(dut_x), 11); lane(0, 12, 20, 5, 1, 1, 0);
    @(negedge clk); chk("t1_x12", 32'(dut_x), 12); chk("t1_done", 32'(burst_done), 1);
    chk("t1_grant_clr", 32'(grant), 0); clear_inputs();
    @(negedge clk); chk("t1_plot_end", 32'(plot), 0); chk("t1_done_end", 32'(burst_done), 0);

    // Round robin over all requesters with single-beat bursts
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) lane(i, 100 + i, 50, i, 1, 1, 0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); chk("t2_rr_grant", 32'(grant), 32'(rr_exp[k]));
    end
    req = '0;
    @(negedge clk);

    // Requester 2 with gaps in valid and blackout set
    do_reset();
    req = 4'b0100;
    @(negedge clk); chk("t3_grant", 32'(grant), 4); req = '0; lane(2, 30, 40, 7, 1, 0, 1);
    @(negedge clk); chk("t3_plot_a", 32'(plot), 1); chk("t3_col_a", 32'(colour), 0);
    chk("t3_x_a", 32'(dut_x), 30); lane(2, 31, 40, 7, 0, 0, 1);
    @(negedge clk); chk("t3_plot_b", 32'(plot), 0); chk("t3_x_hold", 32'(dut_x), 30);
    lane(2, 32, 40, 6, 1, 1, 1);
    @(negedge clk); chk("t3_plot_c", 32'(plot), 1); chk("t3_col_c", 32'(colour), 0);
    chk("t3_x_c", 32'(dut_x), 32); chk("t3_done", 32'(burst_done), 4);

    // Watchdog on a burst that never ends, then hand-over to requester 2
    do_reset();
    req = 4'b0010; lane(1, 50, 60, 3, 1, 0, 0);
    @(negedge clk); chk("t4_grant", 32'(grant), 2); req = 4'b0110;
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk); chk("t4_no_timeout", 32'(timeout_err), 0);
    end
    @(negedge clk); chk("t4_timeout", 32'(timeout_err), 1); chk("t4_grant_clr", 32'(grant), 0);
    @(negedge clk); chk("t4_next_grant", 32'(grant), 4); req = '0; lane(2, 70, 80, 1, 1, 1, 0);
    @(negedge clk); chk("t4_done2", 32'(burst_done), 4);

    // Hold blocks arbitration; asynchronous reset mid-burst
    do_reset();
    hold = 1; req = 4'b0001; lane(0, 1, 2, 3, 1, 0, 0);
    repeat (3) begin
      @(negedge clk); chk("t5_hold_grant", 32'(grant), 0);
    end
    hold = 0;
    @(negedge clk); chk("t5_grant", 32'(grant), 1); req = '0;
    @(negedge clk); chk("t5_plot", 32'(plot), 1);
    #2 resetn = 0;
    #1;
    chk("t5_rst_grant", 32'(grant), 0); chk("t5_rst_plot", 32'(plot), 0);
    chk("t5_rst_X", 32'(dut_x), 0); chk("t5_rst_Y", 32'(dut_y), 0);
    chk("t5_rst_col", 32'(colour), 0); chk("t5_rst_ready", 32'(pix_ready), 0);
    @(negedge clk); resetn = 1; clear_inputs();

    // Off-screen beats
    do_reset();
    req = 4'b0001; lane(0, 320, 5, 4, 1, 0, 0);
    @(negedge clk); chk("t6_grant", 32'(grant), 1); req = '0;
    @(negedge clk);
`ifdef PIXEL_ARB_CLIP_EN
    chk("t6_plot_a", 32'(plot), 0); chk("t6_x_hold", 32'(dut_x), 0);
`else
    chk("t6_plot_a", 32'(plot), 1); chk("t6_x_a", 32'(dut_x), 320);
`endif
    lane(0, 5, 240, 2, 1, 1, 0);
    @(negedge clk);
`ifdef PIXEL_ARB_CLIP_EN
    chk("t6_plot_b", 32'(plot), 0); chk("t6_y_hold", 32'(dut_y), 0);
`else
    chk("t6_plot_b", 32'(plot), 1); chk("t6_y_b", 32'(dut_y), 240);
`endif
    chk("t6_done", 32'(burst_done), 1);

    // Randomized traffic, checked every cycle by the model
    do_reset();
    last_pct = 25;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc % 500 == 0) last_pct = (cyc / 500 == 2) ? 0 : ((cyc / 500) % 2 == 1) ? 3 : 30;
      if (cyc % 700 == 350) resetn = 0;
      else resetn = 1;
      req  = NREQ'($urandom);
      hold = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NREQ; i++)
        lane(i, $urandom_range(0, 340), $urandom_range(0, 250), $urandom_range(0, 7),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < last_pct),
             ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    clear_inputs();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
